xbar_tsi_switch: RTL and testbench

Parametrised time-slot-interchange crossbar for the TDM switch fabric. It is the next-generation generalisation of the fixed-port, fixed-slot switching stage.
- Each frame it captures one word per input port per slot into a ping-pong bank.
- During the following frame it replays the words to any output port in any slot, according to a double-buffered connection map.
- Supports multicast and per-slot idle entries.
- Sits between the input deserialisers and the output serialisers; replaces the single-bank, header-driven switching stage.

---
 rtl/xbar_tsi_switch.sv | 134 +++++++++++++
 tb/tb_xbar_tsi_switch.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_tsi_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xbar_tsi_switch                                                            |
// | Ping-pong time-slot-interchange crossbar with a double-buffered map.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module xbar_tsi_switch #(
  parameter int PORTS = 4,
  parameter int SLOTS = 8,
  parameter int WIDTH = 8,
  localparam int PW = $clog2(PORTS),
  localparam int SW = $clog2(SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [PORTS*WIDTH-1:0] in_data,
  input  logic [PORTS-1:0]       in_valid,
  output logic [PORTS*WIDTH-1:0] out_data,
  output logic [PORTS-1:0]       out_valid,
  output logic [SW-1:0]          out_slot,
  output logic                   frame_start,
  input  logic                   cfg_we,
  input  logic [PW-1:0]          cfg_port,
  input  logic [SW-1:0]          cfg_slot,
  input  logic [PW-1:0]          cfg_src_port,
  input  logic [SW-1:0]          cfg_src_slot,
  input  logic                   cfg_en,
  input  logic                   cfg_commit,
  output logic                   cfg_busy
);

  // Map entry layout: {en, src_port, src_slot}
  localparam int c_EW  = 1 + PW + SW;
  localparam int c_NP2 = 1 << PW;

  logic [SW-1:0]   r_cur_slot;
  logic            r_bank_sel;
  logic            r_pending;
  logic [WIDTH:0]  r_bank   [2][SLOTS][PORTS];
  logic [c_EW-1:0] r_shadow [PORTS][SLOTS];
  logic [c_EW-1:0] r_active [PORTS][SLOTS];

  logic                   w_wrap;
  logic                   w_apply;
  logic [c_EW-1:0]        w_new_entry;
  logic [WIDTH:0]         w_rbank [SLOTS][c_NP2];
  logic [c_EW-1:0]        w_entry [PORTS];
  logic [WIDTH:0]         w_word  [PORTS];
  logic [PORTS*WIDTH-1:0] w_next_data;
  logic [PORTS-1:0]       w_next_valid;

  assign w_wrap      = en && (r_cur_slot == SW'(SLOTS - 1));
  assign w_apply     = w_wrap && (r_pending || cfg_commit);
  assign w_new_entry = {cfg_en, cfg_src_port, cfg_src_slot};
  assign cfg_busy    = r_pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_slot <= '0;
      r_bank_sel <= 1'b0;
      r_pending  <= 1'b0;
    end else if (en) begin
      r_cur_slot <= r_cur_slot + SW'(1);
      if (w_wrap) r_bank_sel <= ~r_bank_sel;
      if (w_apply) r_pending <= 1'b0;
      else if (cfg_commit) r_pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int s = 0; s < SLOTS; s++)
          for (int p = 0; p < PORTS; p++)
            r_bank[b][s][p] <= '0;
    end else if (en) begin
      for (int p = 0; p < PORTS; p++)
        r_bank[r_bank_sel][r_cur_slot][p] <= {in_valid[p], in_data[p*WIDTH +: WIDTH]};
    end
  end

  // Active copies the pre-write shadow, so a same-cycle cfg_we lands in shadow only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < PORTS; o++)
        for (int s = 0; s < SLOTS; s++) begin
          r_shadow[o][s] <= '0;
          r_active[o][s] <= '0;
        end
    end else begin
      if (w_apply)
        for (int o = 0; o < PORTS; o++)
          for (int s = 0; s < SLOTS; s++)
            r_active[o][s] <= r_shadow[o][s];
      for (int o = 0; o < PORTS; o++)
        if (cfg_we && (cfg_port == PW'(o))) r_shadow[o][cfg_slot] <= w_new_entry;
    end
  end

  // Read bank padded to a power-of-two port count; unused source ports read as idle.
  for (genvar s = 0; s < SLOTS; s++) begin : g_rd_slot
    for (genvar p = 0; p < c_NP2; p++) begin : g_rd_port
      if (p < PORTS) begin : g_real
        assign w_rbank[s][p] = r_bank[~r_bank_sel][s][p];
      end else begin : g_pad
        assign w_rbank[s][p] = '0;
      end
    end
  end

  for (genvar o = 0; o < PORTS; o++) begin : g_out
    assign w_entry[o]      = r_active[o][r_cur_slot];
    assign w_word[o]       = w_rbank[w_entry[o][SW-1:0]][w_entry[o][SW +: PW]];
    assign w_next_valid[o] = w_entry[o][c_EW-1] & w_word[o][WIDTH];
    assign w_next_data[o*WIDTH +: WIDTH] = w_entry[o][c_EW-1] ? w_word[o][WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data    <= '0;
      out_valid   <= '0;
      out_slot    <= '0;
      frame_start <= 1'b0;
    end else if (en) begin
      out_data    <= w_next_data;
      out_valid   <= w_next_valid;
      out_slot    <= r_cur_slot;
      frame_start <= (r_cur_slot == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_xbar_tsi_switch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_xbar_tsi_switch                                                         |
// | Frame-level reference model plus directed and random stimulus.             |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_xbar_tsi_switch;
  localparam int PORTS = 4;
  localparam int SLOTS = 8;
  localparam int WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [2:0]  out_slot;
  logic        frame_start;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_port = '0;
  logic [2:0]  cfg_slot = '0;
  logic [1:0]  cfg_src_port = '0;
  logic [2:0]  cfg_src_slot = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_commit = 1'b0;
  logic        cfg_busy;

  xbar_tsi_switch #(.PORTS(PORTS), .SLOTS(SLOTS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_slot(out_slot),
    .frame_start(frame_start), .cfg_we(cfg_we), .cfg_port(cfg_port),
    .cfg_slot(cfg_slot), .cfg_src_port(cfg_src_port), .cfg_src_slot(cfg_src_slot),
    .cfg_en(cfg_en), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 0;
  int mode = 0;  // 0 hold inputs, 1 random, 2 identity pattern

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: whole captured frames and map tables, advanced per en-cycle.
  logic [7:0] cur_d [SLOTS][PORTS];
  logic       cur_v [SLOTS][PORTS];
  logic [7:0] prev_d[SLOTS][PORTS];
  logic       prev_v[SLOTS][PORTS];
  bit         sh_en[PORTS][SLOTS], ac_en[PORTS][SLOTS];
  int         sh_sp[PORTS][SLOTS], ac_sp[PORTS][SLOTS];
  int         sh_ss[PORTS][SLOTS], ac_ss[PORTS][SLOTS];
  int         m_n = 0;
  bit         m_pend = 0;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_valid = '0;
  logic [2:0]  exp_slot = '0;
  logic        exp_fs = 1'b0;

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++)
      for (int p = 0; p < PORTS; p++) begin
        cur_d[s][p] = '0; cur_v[s][p] = 1'b0; prev_d[s][p] = '0; prev_v[s][p] = 1'b0;
        sh_en[p][s] = 0; sh_sp[p][s] = 0; sh_ss[p][s] = 0;
        ac_en[p][s] = 0; ac_sp[p][s] = 0; ac_ss[p][s] = 0;
      end
    m_n = 0; m_pend = 0;
    exp_data = '0; exp_valid = '0; exp_slot = '0; exp_fs = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin
      if (en) begin
        int t;
        t = m_n % SLOTS;
        for (int o = 0; o < PORTS; o++) begin
          if (ac_en[o][t]) begin
            exp_data[o*8 +: 8] = prev_d[ac_ss[o][t]][ac_sp[o][t]];
            exp_valid[o]       = prev_v[ac_ss[o][t]][ac_sp[o][t]];
          end else begin
            exp_data[o*8 +: 8] = '0;
            exp_valid[o]       = 1'b0;
          end
        end
        exp_slot = 3'(t);
        exp_fs   = (t == 0);
        for (int p = 0; p < PORTS; p++) begin
          cur_d[t][p] = in_data[p*8 +: 8];
          cur_v[t][p] = in_valid[p];
        end
        if (t == SLOTS - 1) begin
          if (m_pend || cfg_commit) begin
            ac_en = sh_en; ac_sp = sh_sp; ac_ss = sh_ss;
            m_pend = 0;
          end
          prev_d = cur_d; prev_v = cur_v;
        end else if (cfg_commit) m_pend = 1;
        m_n++;
      end
      if (cfg_we) begin
        sh_en[cfg_port][cfg_slot] = cfg_en;
        sh_sp[cfg_port][cfg_slot] = int'(cfg_src_port);
        sh_ss[cfg_port][cfg_slot] = int'(cfg_src_slot);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("out_data", 64'(out_data), 64'(exp_data));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("out_slot", 64'(out_slot), 64'(exp_slot));
      chk("frame_start", 64'(frame_start), 64'(exp_fs));
      chk("cfg_busy", 64'(cfg_busy), 64'(m_pend));
    end
  end

  task automatic drive_mode();
    if (mode == 1) begin
      in_data = $urandom; in_valid = 4'($urandom);
    end else if (mode == 2) begin
      for (int p = 0; p < PORTS; p++) in_data[p*8 +: 8] = {4'(p), 4'(m_n % SLOTS)};
      in_valid = 4'hF;
    end
  endtask

  task automatic cyc_raw();
    @(negedge clk);
  endtask

  task automatic cyc();
    drive_mode();
    @(negedge clk);
  endtask

  task automatic run_to_slot(input int s);
    int n = 0;
    en = 1'b1;
    while ((m_n % SLOTS) != s && n <= SLOTS) begin cyc(); n++; end
    if ((m_n % SLOTS) != s) chk("run_to_slot_timeout", 64'(m_n % SLOTS), 64'(s));
  endtask

  task automatic map_write(input int o, input int t, input int sp, input int ss, input bit e);
    cfg_we = 1'b1; cfg_port = 2'(o); cfg_slot = 3'(t);
    cfg_src_port = 2'(sp); cfg_src_slot = 3'(ss); cfg_en = e;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic clear_map();
    en = 1'b0;
    for (int o = 0; o < PORTS; o++)
      for (int t = 0; t < SLOTS; t++) map_write(o, t, 0, 0, 1'b0);
  endtask

  task automatic commit_apply();
    en = 1'b1; cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    run_to_slot(0);
    chk("busy_after_apply", 64'(cfg_busy), 64'd0);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2 cmp_on = 1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_data", 64'(out_data), 64'd0);
    chk("reset_busy", 64'(cfg_busy), 64'd0);
    @(negedge clk); rst = 1'b1;

    // Identity map
    en = 1'b0;
    for (int o = 0; o < PORTS; o++)
      for (int t = 0; t < SLOTS; t++) map_write(o, t, o, t, 1'b1);
    mode = 2;
    commit_apply();
    for (int k = 0; k < SLOTS; k++) cyc();
    for (int t = 0; t < SLOTS; t++) begin
      cyc();
      chk("ident_slot", 64'(out_slot), 64'(t));
      chk("ident_fs", 64'(frame_start), 64'(t == 0));
      chk("ident_valid", 64'(out_valid), 64'hF);
      for (int o = 0; o < PORTS; o++)
        chk("ident_data", 64'(out_data[o*8 +: 8]), 64'({4'(o), 4'(t)}));
    end

    // Interchange: out0 slot3 <- port2 slot5
    mode = 1;
    clear_map();
    map_write(0, 3, 2, 5, 1'b1);
    commit_apply();
    run_to_slot(5);
    in_data = $urandom; in_valid = 4'($urandom);
    in_data[23:16] = 8'hA5; in_valid[2] = 1'b1;
    cyc_raw();
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (k >= 3) begin
        chk("xchg_valid", 64'(out_valid), (k == 6) ? 64'h1 : 64'h0);
        if (k == 6) chk("xchg_data_lat7", 64'(out_data[7:0]), 64'hA5);
      end
    end

    // Multicast plus idle
    clear_map();
    for (int o = 0; o < PORTS; o++) map_write(o, 0, 1, 7, 1'b1);
    commit_apply();
    run_to_slot(7);
    in_data = $urandom; in_valid = 4'($urandom);
    in_data[15:8] = 8'h3C; in_valid[1] = 1'b1;
    cyc_raw();
    cyc();
    chk("mcast_slot", 64'(out_slot), 64'd0);
    chk("mcast_valid", 64'(out_valid), 64'hF);
    chk("mcast_data", 64'(out_data), 64'h3C3C3C3C);
    run_to_slot(7);
    in_data[15:8] = 8'h3C; in_valid[1] = 1'b0;
    cyc_raw();
    cyc();
    chk("mcast_inv_valid", 64'(out_valid), 64'h0);
    chk("mcast_inv_data", 64'(out_data), 64'h3C3C3C3C);

    // Commit timing
    en = 1'b0;
    map_write(0, 0, 3, 2, 1'b1);
    run_to_slot(2);
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    chk("busy_rise", 64'(cfg_busy), 64'd1);
    run_to_slot(0);
    chk("busy_fall", 64'(cfg_busy), 64'd0);
    run_to_slot(7);
    cfg_commit = 1'b1;
    cfg_we = 1'b1; cfg_port = 2'd2; cfg_slot = 3'd4; cfg_src_port = 2'd0;
    cfg_src_slot = 3'd1; cfg_en = 1'b1;
    cyc();
    cfg_commit = 1'b0; cfg_we = 1'b0;
    chk("busy_wrap_commit", 64'(cfg_busy), 64'd0);
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    in_data = $urandom; in_valid = 4'($urandom);
    in_data[7:0] = 8'h5A; in_valid[0] = 1'b1;
    cyc_raw();
    run_to_slot(4);
    cyc();
    chk("old_entry_slot", 64'(out_slot), 64'd4);
    chk("old_entry_idle", 64'(out_valid[2]), 64'd0);
    run_to_slot(4);
    cyc();
    chk("new_entry_valid", 64'(out_valid[2]), 64'd1);
    chk("new_entry_data", 64'(out_data[23:16]), 64'h5A);

    // Stall
    run_to_slot(3);
    cyc();
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("stall_slot", 64'(out_slot), 64'd3);
      chk("stall_busy", 64'(cfg_busy), 64'd0);
    end
    en = 1'b1;
    cyc();
    chk("resume_slot", 64'(out_slot), 64'd4);

    // Reset mid-frame with traffic and a pending commit
    mode = 2;
    en = 1'b0;
    for (int o = 0; o < PORTS; o++)
      for (int t = 0; t < SLOTS; t++) map_write(o, t, o, t, 1'b1);
    commit_apply();
    for (int k = 0; k < SLOTS; k++) cyc();
    run_to_slot(4);
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_slot", 64'(out_slot), 64'd0);
    chk("rst_fs", 64'(frame_start), 64'd0);
    chk("rst_busy", 64'(cfg_busy), 64'd0);
    @(negedge clk); rst = 1'b1;
    en = 1'b1;
    for (int k = 0; k < 2 * SLOTS; k++) begin
      cyc();
      chk("post_rst_valid", 64'(out_valid), 64'd0);
    end

    // Random traffic, map edits and commits
    mode = 1;
    for (int k = 0; k < 800; k++) begin
      en = ($urandom_range(0, 9) != 0);
      cfg_we = ($urandom_range(0, 2) == 0);
      cfg_port = 2'($urandom); cfg_slot = 3'($urandom);
      cfg_src_port = 2'($urandom); cfg_src_slot = 3'($urandom);
      cfg_en = ($urandom_range(0, 3) != 0);
      cfg_commit = en && ($urandom_range(0, 11) == 0);
      cyc();
    end
    cfg_we = 1'b0; cfg_commit = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
